// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit
package ifu_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;
  typedef enum logic [1:0] {RUN, WAIT, FAULT} state_t;
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;
endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// fetch_fifo: prefetch buffer of {pc, instr} entries with flush and combinational head read
// Ports: clk, reset (async, active-high), push/din write, pop removes head,
// flush empties the buffer, dout is the head entry, count is current occupancy.
import ifu_pkg::*;
module fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  entry_t                     din,
  output entry_t                     dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC generation, imem request credit and prefetch to decode
// Ports: clk, reset (async, active-high); imem_req/imem_addr/imem_rdata to a
// synchronous instruction memory (one-cycle read latency); if_valid/if_ready/
// if_instr/if_pc handshake to decode; redirect_valid/redirect_pc from the
// datapath; fetch_fault flags a misaligned redirect.
// Optional feature: define IFU_ALIGN_CHECK_EN to trap misaligned redirects
// in a sticky FAULT state; otherwise redirect targets are forced word-aligned.
import ifu_pkg::*;
module instruction_fetch_unit #(
  parameter int              FIFO_DEPTH = 4,
  parameter int              ADDR_W     = 5,
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               fetch_fault
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  state_t state, next_state;
  logic [PC_W-1:0] fetch_pc, inflight_pc, target;
  logic inflight, credit, pop, push, misaligned;
  logic [CW-1:0] count;
  entry_t din, head;
`ifdef IFU_ALIGN_CHECK_EN
  assign target = redirect_pc;
  assign misaligned = |redirect_pc[1:0];
`else
  assign target = redirect_pc & ~PC_W'(3);
  assign misaligned = 1'b0;
`endif
  // An outstanding request already owns a FIFO slot, so it counts against credit.
  assign credit = ({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(FIFO_DEPTH);
  assign pop = if_valid && if_ready;
  assign push = inflight && !redirect_valid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else state <= next_state;
  end
  // A pop in the same cycle frees a slot, so RUN only parks in WAIT when none occurs.
  always_comb begin
    next_state = redirect_valid ? (misaligned ? FAULT : RUN) :
                 state == RUN   ? ((credit || pop) ? RUN : WAIT) :
                 state == WAIT  ? (pop ? RUN : WAIT) : state;
  end
  always_comb begin
    imem_req = !reset && state == RUN && credit && !redirect_valid;
`ifdef IFU_ALIGN_CHECK_EN
    fetch_fault = state == FAULT;
`else
    fetch_fault = 1'b0;
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) inflight_pc <= fetch_pc;
      fetch_pc <= redirect_valid ? target : imem_req ? fetch_pc + PC_STEP : fetch_pc;
    end
  end
  assign din = '{pc: inflight_pc, instr: imem_rdata};
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .dout  (head),
    .count (count)
  );
  assign imem_addr = fetch_pc[ADDR_W+1:2];
  assign if_valid = count != '0 && !redirect_valid;
  assign if_instr = head.instr;
  assign if_pc = head.pc;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized self-checking bench with a stream-order reference model
module tb_instruction_fetch_unit;
  logic clk = 0;
  logic reset = 1;
  logic imem_req;
  logic [4:0] imem_addr;
  logic [31:0] imem_rdata;
  logic if_valid;
  logic if_ready = 0;
  logic [31:0] if_instr, if_pc;
  logic redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic fetch_fault;
  logic [31:0] mem [32];
  int checks = 0, passes = 0;
  logic xfer;
  logic [31:0] want, exp_pc = 0;
  int reqs = 0, xfers = 0, xfer_total = 0;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) imem_rdata <= imem_req ? mem[imem_addr] : $urandom;

  function automatic logic [31:0] tgt(input logic [31:0] rp);
`ifdef IFU_ALIGN_CHECK_EN
    return rp;
`else
    return {rp[31:2], 2'b00};
`endif
  endfunction

  // Expected delivery order: consecutive words from the last reset/redirect target.
  task automatic cycle(input logic rs, input logic rv, input logic [31:0] rp, input logic rd);
    @(negedge clk);
    reset = rs; redirect_valid = rv; redirect_pc = rp; if_ready = rd;
    #1;
    xfer = if_valid && if_ready;
    want = exp_pc;
    if (imem_req) reqs++;
    if (xfer) begin xfers++; xfer_total++; end
    if (rs) begin exp_pc = 32'h0; reqs = 0; xfers = 0; end
    else if (rv) begin exp_pc = tgt(rp); reqs = 0; xfers = 0; end
    else if (xfer) exp_pc += 4;
  endtask

  task automatic test_reset;
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    checks++; if (imem_req !== 0) $display("FAIL reset_req got %b want 0", imem_req); else passes++;
    checks++; if (if_valid !== 0) $display("FAIL reset_valid got %b want 0", if_valid); else passes++;
    checks++; if (if_instr !== 0) $display("FAIL reset_instr got %h want 0", if_instr); else passes++;
    checks++; if (if_pc !== 0) $display("FAIL reset_pc got %h want 0", if_pc); else passes++;
    checks++; if (fetch_fault !== 0) $display("FAIL reset_fault got %b want 0", fetch_fault); else passes++;
    checks++; if (imem_addr !== 0) $display("FAIL reset_addr got %h want 0", imem_addr); else passes++;
  endtask

  task automatic test_stream;
    for (int c = 0; c < 20; c++) begin
      cycle(0, 0, 0, 1);
      if (c == 0) begin
        checks++; if (imem_req !== 1 || imem_addr !== 0) $display("FAIL first_req got req=%b addr=%h want 1/0", imem_req, imem_addr); else passes++;
      end
      if (c < 2) begin
        checks++; if (if_valid !== 0) $display("FAIL stream_early_valid c=%0d got %b want 0", c, if_valid); else passes++;
      end else begin
        checks++;
        if (if_valid !== 1 || if_pc !== 32'((c-2)*4) || if_instr !== 32'(c-1))
          $display("FAIL stream c=%0d got v=%b pc=%h instr=%h want 1/%h/%h", c, if_valid, if_pc, if_instr, 32'((c-2)*4), 32'(c-1));
        else passes++;
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] hpc, hin;
    for (int c = 0; c < 10; c++) begin
      cycle(0, 0, 0, 0);
      if (c == 0) begin hpc = if_pc; hin = if_instr; end
      else begin
        checks++; if (if_valid !== 1 || if_pc !== hpc || if_instr !== hin) $display("FAIL hold c=%0d got %b/%h/%h want 1/%h/%h", c, if_valid, if_pc, if_instr, hpc, hin); else passes++;
      end
    end
    checks++; if (imem_req !== 0) $display("FAIL wait_req got %b want 0", imem_req); else passes++;
    checks++; if (reqs - xfers !== 4) $display("FAIL buffered got %0d want 4", reqs - xfers); else passes++;
    for (int c = 0; c < 12; c++) begin
      cycle(0, 0, 0, 1);
      checks++;
      if (if_valid !== 1 || if_pc !== want || if_instr !== mem[want[6:2]])
        $display("FAIL drain c=%0d got %b/%h/%h want 1/%h/%h", c, if_valid, if_pc, if_instr, want, mem[want[6:2]]);
      else passes++;
    end
  endtask

  task automatic test_redirect;
    cycle(0, 1, 32'h20, 0);
    for (int c = 0; c < 4; c++) cycle(0, 0, 0, 0);
    checks++; if (reqs - xfers !== 4) $display("FAIL pre_redirect_occ got %0d want 4", reqs - xfers); else passes++;
    cycle(0, 1, 32'h40, 1);
    checks++; if (if_valid !== 0 || imem_req !== 0) $display("FAIL redir_cycle got v=%b req=%b want 0/0", if_valid, imem_req); else passes++;
    cycle(0, 0, 0, 1);
    checks++; if (imem_req !== 1 || imem_addr !== 5'd16 || if_valid !== 0) $display("FAIL redir_r1 got req=%b addr=%h v=%b want 1/10/0", imem_req, imem_addr, if_valid); else passes++;
    cycle(0, 0, 0, 1);
    checks++; if (if_valid !== 0) $display("FAIL redir_r2 got v=%b want 0", if_valid); else passes++;
    cycle(0, 0, 0, 1);
    checks++; if (if_valid !== 1 || if_pc !== 32'h40 || if_instr !== mem[16]) $display("FAIL redir_r3 got %b/%h/%h want 1/40/%h", if_valid, if_pc, if_instr, mem[16]); else passes++;
    for (int c = 0; c < 6; c++) begin
      cycle(0, 0, 0, 1);
      checks++; if (!xfer || if_pc !== want || if_instr !== mem[want[6:2]]) $display("FAIL redir_stream c=%0d got %b/%h/%h want 1/%h/%h", c, xfer, if_pc, if_instr, want, mem[want[6:2]]); else passes++;
    end
  endtask

  task automatic test_wrap;
    cycle(0, 1, 32'hFFFF_FFFC, 1);
    cycle(0, 0, 0, 1);
    checks++; if (imem_req !== 1 || imem_addr !== 5'd31) $display("FAIL wrap_r1 got %b/%h want 1/1f", imem_req, imem_addr); else passes++;
    cycle(0, 0, 0, 1);
    checks++; if (imem_req !== 1 || imem_addr !== 5'd0) $display("FAIL wrap_r2 got %b/%h want 1/0", imem_req, imem_addr); else passes++;
    cycle(0, 0, 0, 1);
    checks++; if (if_valid !== 1 || if_pc !== 32'hFFFF_FFFC || if_instr !== mem[31]) $display("FAIL wrap_top got %b/%h/%h want 1/fffffffc/%h", if_valid, if_pc, if_instr, mem[31]); else passes++;
    cycle(0, 0, 0, 1);
    checks++; if (if_valid !== 1 || if_pc !== 32'h0 || if_instr !== mem[0]) $display("FAIL wrap_zero got %b/%h/%h want 1/0/%h", if_valid, if_pc, if_instr, mem[0]); else passes++;
  endtask

  task automatic test_align;
    cycle(0, 1, 32'h42, 1);
`ifdef IFU_ALIGN_CHECK_EN
    for (int c = 0; c < 5; c++) begin
      cycle(0, 0, 0, 1);
      checks++; if (fetch_fault !== 1 || imem_req !== 0 || if_valid !== 0) $display("FAIL fault_hold c=%0d got f=%b req=%b v=%b want 1/0/0", c, fetch_fault, imem_req, if_valid); else passes++;
    end
    cycle(0, 1, 32'h10, 1);
    cycle(0, 0, 0, 1);
    checks++; if (fetch_fault !== 0 || imem_req !== 1 || imem_addr !== 5'd4) $display("FAIL fault_clear got f=%b req=%b addr=%h want 0/1/4", fetch_fault, imem_req, imem_addr); else passes++;
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    checks++; if (if_valid !== 1 || if_pc !== 32'h10 || if_instr !== mem[4]) $display("FAIL fault_resume got %b/%h/%h want 1/10/%h", if_valid, if_pc, if_instr, mem[4]); else passes++;
`else
    cycle(0, 0, 0, 1);
    checks++; if (fetch_fault !== 0 || imem_req !== 1 || imem_addr !== 5'd16) $display("FAIL mask_r1 got f=%b req=%b addr=%h want 0/1/10", fetch_fault, imem_req, imem_addr); else passes++;
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    checks++; if (if_valid !== 1 || if_pc !== 32'h40 || if_instr !== mem[16]) $display("FAIL mask_r3 got %b/%h/%h want 1/40/%h", if_valid, if_pc, if_instr, mem[16]); else passes++;
`endif
  endtask

  task automatic test_random;
    int start;
    logic rv, rd;
    logic [31:0] rp;
    for (int k = 0; k < 32; k++) mem[k] = $urandom;
    start = xfer_total;
    cycle(0, 1, $urandom & 32'hFFFF_FFFC, 1);
    for (int c = 0; c < 400; c++) begin
      rv = $urandom_range(0, 19) == 0;
`ifdef IFU_ALIGN_CHECK_EN
      rp = $urandom & 32'hFFFF_FFFC;
`else
      rp = $urandom;
`endif
      rd = $urandom_range(0, 3) != 0;
      cycle(0, rv, rp, rd);
      if (rv) begin
        checks++; if (if_valid !== 0 || imem_req !== 0) $display("FAIL rand_redir c=%0d got v=%b req=%b want 0/0", c, if_valid, imem_req); else passes++;
      end
      if (xfer) begin
        checks++; if (if_pc !== want || if_instr !== mem[want[6:2]]) $display("FAIL rand_xfer c=%0d got %h/%h want %h/%h", c, if_pc, if_instr, want, mem[want[6:2]]); else passes++;
      end
      if (!rv && reqs - xfers > 4) begin
        checks++; $display("FAIL rand_occ c=%0d got %0d want <=4", c, reqs - xfers);
      end
    end
    checks++; if (xfer_total - start < 100) $display("FAIL rand_progress got %0d want >=100", xfer_total - start); else passes++;
  endtask

  task automatic test_reset_mid;
    cycle(0, 1, 32'h60, 0);
    for (int c = 0; c < 4; c++) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    checks++;
    if (imem_req !== 0 || if_valid !== 0 || if_instr !== 0 || if_pc !== 0 || fetch_fault !== 0 || imem_addr !== 0)
      $display("FAIL mid_reset got req=%b v=%b instr=%h pc=%h f=%b addr=%h want all 0", imem_req, if_valid, if_instr, if_pc, fetch_fault, imem_addr);
    else passes++;
    cycle(1, 0, 0, 1);
    for (int c = 0; c < 4; c++) begin
      cycle(0, 0, 0, 1);
      if (c == 0) begin
        checks++; if (imem_req !== 1 || imem_addr !== 0) $display("FAIL restart_req got %b/%h want 1/0", imem_req, imem_addr); else passes++;
      end
      if (c == 2) begin
        checks++; if (if_valid !== 1 || if_pc !== 0 || if_instr !== mem[0]) $display("FAIL restart_data got %b/%h/%h want 1/0/%h", if_valid, if_pc, if_instr, mem[0]); else passes++;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) mem[k] = 32'(k + 1);
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect;
    test_wrap;
    test_align;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage sitting upstream of the single-cycle datapath's decode/control logic. It owns the 32-bit program counter, issues word reads to a synchronous instruction memory and buffers returned instructions in a small prefetch FIFO. Instructions and their PCs are presented to decode over a valid/ready handshake. Branch/jump targets from the datapath redirect the PC and flush all wrong-path state.

## Interface
- FIFO_DEPTH, 4, prefetch entries; power of two, ≥2
- ADDR_W, 5, instruction-memory word-address width (32 words)
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- imem_req  out  1  read request this cycle
- imem_addr  out  ADDR_W  word address, equal to pc[ADDR_W+1:2]
- imem_rdata  in  32  read data, valid exactly one cycle after imem_req
- if_valid  out  1  if_instr/if_pc hold a valid entry
- if_ready  in  1  decode accepts the entry
- if_instr  out  32  instruction at FIFO head
- if_pc  out  32  byte PC of that instruction
- redirect_valid  in  1  datapath requests a PC change
- redirect_pc  in  32  byte target address
- fetch_fault  out  1  misaligned redirect seen (only with IFU_ALIGN_CHECK_EN; else tied 0)

## Operation
- States: RUN, WAIT, FAULT. Reset → RUN.
- RUN: imem_req=1 when (count + inflight + pop-this-cycle-adjust) allows; precisely, request only if count + inflight < FIFO_DEPTH, where inflight ∈ {0,1}. On request, fetch_pc += 4 (mod 2^32 wrap).
- RUN → WAIT when no credit; WAIT → RUN when credit returns (a pop occurs). imem_req=0 in WAIT.
- Response: inflight request's imem_rdata pushed with its PC at the end of the following cycle, unless squashed.
- Pop: if_valid && if_ready removes head. Simultaneous push and pop allowed in any occupancy, count unchanged.
- Redirect (highest priority): fetch_pc ← redirect_pc, FIFO emptied, inflight response squashed (not pushed), if_valid forced 0 in the redirect cycle so no transfer occurs; no imem_req in the redirect cycle. Fetch from the new PC starts the next cycle.
- Redirect while in WAIT or FAULT: accepted identically, next state RUN (subject to alignment check).
- count width: $clog2(FIFO_DEPTH+1); read/write pointers $clog2(FIFO_DEPTH) bits, natural wrap.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC[ADDR_W+1:2], if_valid=0, if_instr=0, if_pc=0, fetch_fault=0, count=0, inflight=0.
- First request in the first cycle after reset deasserts (cycle 0); data pushed end of cycle 1; if_valid=1 in cycle 2. Fetch-to-decode latency 2 cycles.
- Redirect at cycle R: request to target in R+1, if_valid for target in R+3.
- Steady state with if_ready=1: one instruction per cycle.
- if_instr/if_pc stable while if_valid && !if_ready.
- Reset asserted mid-operation: all state cleared immediately; pending imem_rdata ignored.

## Configuration
- IFU_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]≠0 enters FAULT, sets fetch_fault (sticky), flushes as normal, stops requests. Only reset or an aligned redirect leaves FAULT and clears fetch_fault.
- Undefined: redirect_pc[1:0] masked to 00; FAULT state unreachable; fetch_fault tied 0.

## Structure
- Shared package ifu_pkg: state enum (RUN, WAIT, FAULT), INSTR_W=32, PC_W=32, PC_STEP=4.
- One sub-module: fetch_fifo (parameterised depth, push/pop/flush, count output, combinational head read).
- PC, credit and state logic in the top module.

## Test plan
- Reset release, imem returns mem[k]=k+1, if_ready=1 → if_valid in cycle 2, if_pc sequence 0,4,8,…, if_instr 1,2,3,…, one per cycle.
- if_ready=0 for 10 cycles → exactly 4 entries buffered, imem_req low (WAIT), no lost/duplicated instruction after if_ready returns.
- redirect_valid with redirect_pc=0x40 while FIFO holds 3 entries and a request is inflight → if_valid 0 in redirect cycle, next if_pc=0x40 at R+3, no stale entry delivered.
- fetch_pc=0xFFFF_FFFC fetched → next request PC wraps to 0x0000_0000, imem_addr=0.
- With IFU_ALIGN_CHECK_EN, redirect_pc=0x42 → fetch_fault=1, imem_req stays 0; then redirect_pc=0x10 → fault clears, if_pc=0x10 delivered. Without the macro, 0x42 fetches from 0x40.
- Assert reset while FIFO full and inflight → all outputs at reset values in the same cycle; after release fetch restarts at RESET_PC.
